// File: rtl/serial_frame_demux_pkg.sv
// Shared types for the serial frame demultiplexer.
// Field order on the line doubles as the FSM state encoding.
package serial_demux_pkg;

    localparam logic [2:0] FLD_START = 3'd0;
    localparam logic [2:0] FLD_ADDR  = 3'd1;
    localparam logic [2:0] FLD_LEN   = 3'd2;
    localparam logic [2:0] FLD_DATA  = 3'd3;
    localparam logic [2:0] FLD_PAR   = 3'd4;
    localparam logic [2:0] FLD_STOP  = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = FLD_START,
        ADDR     = FLD_ADDR,
        LEN      = FLD_LEN,
        DATA     = FLD_DATA,
        PAR      = FLD_PAR,
        STOP     = FLD_STOP,
        ERR_WAIT = 3'd6
    } state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_frame_demux_onehot_dec.sv
// Address to one-hot channel select; all-zero when disabled
// or when the address names a channel that does not exist.
module onehot_dec #(
    parameter int N  = 4,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [AW-1:0] addr_i,
    input  logic          en_i,
    output logic [N-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (en_i && (addr_i == AW'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_frame_demux.sv
// Serial frame demultiplexer: decodes start/addr/len/data/parity/stop
// frames from one serial line and routes payload bits to NCH channels.
module serial_frame_demux
    import serial_demux_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int ADDR_W    = $clog2(NCH),
    parameter int LEN_W     = 3,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sin,
    output logic [NCH-1:0] ch_sel,
    output logic           dout,
    output logic           dout_vld,
    output logic           busy,
    output logic           frame_done,
    output logic           err
);

    localparam int CNT_W = max_w(ADDR_W, LEN_W);
    localparam state_t AFTER_DATA = PARITY_EN ? PAR : STOP;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              par_q;
    logic              bad_q;
    logic [NCH-1:0]    ch_sel_q;
    logic              dout_q;
    logic              vld_q;
    logic              done_q;
    logic              err_q;

    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W:0]    len_ext;
    logic [LEN_W-1:0]  len_d;
    logic [CNT_W:0]    cnt_inc;
    logic [CNT_W:0]    len_cmp;
    logic [NCH-1:0]    oh;
    logic              in_range;

    assign addr_ext = {addr_q, sin};
    assign addr_d   = addr_ext[ADDR_W-1:0];
    assign len_ext  = {len_q, sin};
    assign len_d    = len_ext[LEN_W-1:0];
    assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign len_cmp  = (CNT_W+1)'(len_q);
    assign in_range = |oh;

    onehot_dec #(
        .N  (NCH),
        .AW (ADDR_W)
    ) u_dec (
        .addr_i   (addr_q),
        .en_i     (1'b1),
        .onehot_o (oh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            par_q    <= 1'b0;
            bad_q    <= 1'b0;
            ch_sel_q <= '0;
            dout_q   <= 1'b0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ch_sel_q <= '0;
            dout_q   <= 1'b0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_q <= ADDR;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        len_q   <= '0;
                        par_q   <= 1'b0;
                        bad_q   <= 1'b0;
                    end
                end
                ADDR: begin
                    addr_q <= addr_d;
                    par_q  <= par_q ^ sin;
                    cnt_q  <= cnt_inc[CNT_W-1:0];
                    if (cnt_inc == (CNT_W+1)'(ADDR_W)) begin
                        cnt_q   <= '0;
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    len_q <= len_d;
                    par_q <= par_q ^ sin;
                    cnt_q <= cnt_inc[CNT_W-1:0];
                    // addr_q is complete here; flag unroutable frames
                    if (!in_range) begin
                        bad_q <= 1'b1;
                    end
                    if (cnt_inc == (CNT_W+1)'(LEN_W)) begin
                        cnt_q   <= '0;
                        state_q <= (len_d == '0) ? AFTER_DATA : DATA;
                    end
                end
                DATA: begin
                    dout_q   <= sin;
                    vld_q    <= in_range;
                    ch_sel_q <= oh;
                    par_q    <= par_q ^ sin;
                    cnt_q    <= cnt_inc[CNT_W-1:0];
                    if (cnt_inc == len_cmp) begin
                        cnt_q   <= '0;
                        state_q <= AFTER_DATA;
                    end
                end
                PAR: begin
                    if (par_q ^ sin) begin
                        bad_q <= 1'b1;
                    end
                    cnt_q   <= '0;
                    state_q <= STOP;
                end
                STOP: begin
                    cnt_q <= '0;
                    if (sin && !bad_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= sin ? IDLE : ERR_WAIT;
                    end
                end
                ERR_WAIT: begin
                    if (sin) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_sel     = ch_sel_q;
    assign dout       = dout_q;
    assign dout_vld   = vld_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_serial_frame_demux.sv
// Scoreboard bench for serial_frame_demux (NCH=4, LEN_W=3, parity on).
// Expected payload bits and frame outcomes are queued as frames are sent.
module tb_serial_frame_demux;

    localparam int NCH = 4;

    typedef struct packed {
        logic [NCH-1:0] ch;
        logic           b;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           sin;
    logic [NCH-1:0] ch_sel;
    logic           dout;
    logic           dout_vld;
    logic           busy;
    logic           frame_done;
    logic           err;

    exp_t       exp_q[$];
    logic [1:0] evt_q[$];
    int         n_tests;
    int         n_fail;
    int         done_cnt;
    int         err_cnt;
    bit         mon_en;
    exp_t       m_e;
    logic [1:0] m_ev;

    serial_frame_demux #(
        .NCH       (NCH),
        .LEN_W     (3),
        .PARITY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .ch_sel     (ch_sel),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_frame(input int a, input int l,
                              input logic [7:0] d,
                              input bit bad_par, input logic stop);
        logic [1:0] av;
        logic [2:0] lv;
        logic       p;
        exp_t       e;
        av = a[1:0];
        lv = l[2:0];
        p  = 1'b0;
        drive_bit(1'b0);
        for (int i = 1; i >= 0; i--) begin
            p ^= av[i];
            drive_bit(av[i]);
        end
        for (int i = 2; i >= 0; i--) begin
            p ^= lv[i];
            drive_bit(lv[i]);
        end
        for (int i = l - 1; i >= 0; i--) begin
            e.ch = NCH'(1) << av;
            e.b  = d[i];
            exp_q.push_back(e);
            p ^= d[i];
            drive_bit(d[i]);
        end
        drive_bit(p ^ bad_par);
        evt_q.push_back((stop && !bad_par) ? 2'b10 : 2'b01);
        drive_bit(stop);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_vld", 32'(dout_vld), 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("ch_sel", 32'(ch_sel), 32'(m_e.ch));
                    chk("dout", 32'(dout), 32'(m_e.b));
                end
            end else if (ch_sel != '0) begin
                chk("ch_sel_idle", 32'(ch_sel), 32'd0);
            end
            if (frame_done) done_cnt++;
            if (err) err_cnt++;
            if (frame_done || err) begin
                if (evt_q.size() == 0) begin
                    chk("unexp_evt", 32'({frame_done, err}), 32'd0);
                end else begin
                    m_ev = evt_q.pop_front();
                    chk("evt", 32'({frame_done, err}), 32'(m_ev));
                end
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;
        err_cnt  = 0;
        mon_en   = 1'b0;
        sin      = 1'b1;
        rst_n    = 1'b1;
        #10 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ch_sel", 32'(ch_sel), 32'd0);
        chk("rst_vld", 32'(dout_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) drive_bit(1'b1);

        // reset asserted mid-DATA, no scoreboard involvement
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        #50;
        chk("pre_rst_vld", 32'(dout_vld), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ch_sel", 32'(ch_sel), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_vld", 32'(dout_vld), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(frame_done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        sin   = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'b1);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        mon_en = 1'b1;

        send_frame(2, 3, 8'b101, 1'b0, 1'b1);
        repeat (2) drive_bit(1'b1);
        send_frame(2, 3, 8'b101, 1'b1, 1'b1);
        repeat (2) drive_bit(1'b1);
        send_frame(1, 0, 8'b0, 1'b0, 1'b1);
        repeat (2) drive_bit(1'b1);

        send_frame(1, 2, 8'b10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b0);
            chk("errwait_busy", 32'(busy), 32'd1);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("errwait_exit", 32'(busy), 32'd0);

        send_frame(3, 2, 8'b11, 1'b0, 1'b1);
        send_frame(0, 4, 8'b1001, 1'b0, 1'b1);
        repeat (4) drive_bit(1'b1);

        chk("sb_data_left", 32'(exp_q.size()), 32'd0);
        chk("sb_evt_left", 32'(evt_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd4);
        chk("err_count", 32'(err_cnt), 32'd2);
        chk("end_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
